// File: rtl/alu_op_sequencer_if.sv
// Button/switch inputs and register-control outputs of the ALU operation sequencer.
// master = the sequencer itself, slave = the board/datapath side that feeds and consumes it.
interface alu_op_sequencer_if;
    logic       btn_execute;
    logic [3:0] operation;
    logic       op_done;
    logic       enable_A;
    logic       enable_B;
    logic       enable_Y;
    logic       op_start;
    logic [3:0] op_sel;
    logic       busy;
    logic       error;
    logic [2:0] state_out;

    // Handshake: op_start is a one-cycle request; op_done is a one-cycle
    // response that is only honoured while the sequencer waits in S_WAIT_DONE.
    modport master (
        input  btn_execute, operation, op_done,
        output enable_A, enable_B, enable_Y, op_start, op_sel, busy, error, state_out
    );

    modport slave (
        output btn_execute, operation, op_done,
        input  enable_A, enable_B, enable_Y, op_start, op_sel, busy, error, state_out
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Execute-button sequencer for the A/B/Y operand registers and the operation unit.
// Optional macro BTN_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES stable-high filter in the button path.
module alu_op_sequencer #(
    parameter logic [15:0] MULTI_OPS       = 16'hFF00,
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_op_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_LOAD_A    = 3'd0,
        S_WR_A      = 3'd1,
        S_WAIT_B    = 3'd2,
        S_WR_B      = 3'd3,
        S_EXEC      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_WR_Y      = 3'd6,
        S_SHOW      = 3'd7
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          start_nxt;
    logic          set_error;
    logic          clr_error;

    logic          sync1;
    logic          sync2;
    logic          press;

    logic          enable_a_q;
    logic          enable_b_q;
    logic          enable_y_q;
    logic          op_start_q;
    logic [3:0]    op_sel_q;
    logic          busy_q;
    logic          error_q;

    // Synchronizer flops reset high so a button held through reset looks
    // like an already-seen level rather than a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.btn_execute;
            sync2 <= sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DBW-1:0] db_cnt;
    logic           db_level;
    logic           db_prev;

    // Level rises after DEBOUNCE_CYCLES consecutive high samples, drops on any low sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt   <= DBW'(DEBOUNCE_CYCLES);
            db_level <= 1'b1;
            db_prev  <= 1'b1;
        end else begin
            db_prev <= db_level;
            if (!sync2) begin
                db_cnt   <= '0;
                db_level <= 1'b0;
            end else if (db_cnt < DBW'(DEBOUNCE_CYCLES)) begin
                db_cnt <= db_cnt + 1'b1;
                if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= 1'b1;
                end
            end
        end
    end

    assign press = db_level & ~db_prev;
`else
    logic btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= sync2;
        end
    end

    assign press = sync2 & ~btn_prev;
`endif

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        set_error = 1'b0;
        clr_error = 1'b0;
        case (state)
            S_LOAD_A: begin
                if (press) state_nxt = S_WR_A;
            end
            S_WR_A: begin
                state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (press) state_nxt = S_WR_B;
            end
            S_WR_B: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (MULTI_OPS[bus.operation]) begin
                    state_nxt = S_WAIT_DONE;
                    start_nxt = 1'b1;
                end else begin
                    state_nxt = S_WR_Y;
                end
            end
            S_WAIT_DONE: begin
                // A done arriving on the last allowed cycle still wins over the timeout.
                if (bus.op_done) begin
                    state_nxt = S_WR_Y;
                end else if (timeout_hit) begin
                    state_nxt = S_SHOW;
                    set_error = 1'b1;
                end
            end
            S_WR_Y: begin
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_nxt = S_LOAD_A;
                    clr_error = 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOAD_A;
            end
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up
    // exactly with the cycle spent in its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD_A;
            wait_cnt   <= '0;
            enable_a_q <= 1'b0;
            enable_b_q <= 1'b0;
            enable_y_q <= 1'b0;
            op_start_q <= 1'b0;
            op_sel_q   <= 4'h0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            enable_a_q <= (state_nxt == S_WR_A);
            enable_b_q <= (state_nxt == S_WR_B);
            enable_y_q <= (state_nxt == S_WR_Y);
            op_start_q <= start_nxt;
            busy_q     <= (state_nxt == S_EXEC) || (state_nxt == S_WAIT_DONE) ||
                          (state_nxt == S_WR_Y);
            if ((state == S_WAIT_DONE) && (state_nxt == S_WAIT_DONE)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_EXEC) begin
                op_sel_q <= bus.operation;
            end
            if (set_error) begin
                error_q <= 1'b1;
            end else if (clr_error) begin
                error_q <= 1'b0;
            end
        end
    end

    assign bus.enable_A  = enable_a_q;
    assign bus.enable_B  = enable_b_q;
    assign bus.enable_Y  = enable_y_q;
    assign bus.op_start  = op_start_q;
    assign bus.op_sel    = op_sel_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;
    assign bus.state_out = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: randomized opcodes and done delays
// checked against a transaction-level model of press/load/execute/show behaviour.
module tb_alu_op_sequencer;

  localparam logic [15:0] MULTI_REF   = 16'hFF00;
  localparam int          TIMEOUT_REF = 255;
`ifdef BTN_DEBOUNCE_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MULTI_OPS       (16'hFF00),
    .TIMEOUT_CYCLES  (255),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cnt_a, cnt_b, cnt_y, cnt_start, overlap, busy_bad;
  logic [3:0] exp_q[$];

  // pulse counters sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      cnt_a     += int'(bus.enable_A);
      cnt_b     += int'(bus.enable_B);
      cnt_y     += int'(bus.enable_Y);
      cnt_start += int'(bus.op_start);
      if ((int'(bus.enable_A) + int'(bus.enable_B) + int'(bus.enable_Y) + int'(bus.op_start)) > 1)
        overlap++;
      if (bus.busy !== ((bus.state_out >= 3'd4) && (bus.state_out <= 3'd6)))
        busy_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_a = 0; cnt_b = 0; cnt_y = 0; cnt_start = 0; overlap = 0; busy_bad = 0;
  endtask

  task automatic press_btn();
    bus.btn_execute = 1'b1;
    repeat (HOLD) step();
    bus.btn_execute = 1'b0;
    repeat (4) step();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.state_out !== s && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (bus.state_out !== s) begin
      errors++;
      $display("FAIL %s: state_out=%0d expected %0d within %0d cycles", name, bus.state_out, s, budget);
    end
  endtask

  task automatic return_to_a(input string name);
    press_btn();
    wait_state(3'd0, 40, name);
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL %s_error_clear: error=%0b expected 0", name, bus.error);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.btn_execute = 1'b0;
    bus.operation = 4'h0;
    bus.op_done = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.state_out !== 3'd0) begin
      errors++; $display("FAIL reset_state: state_out=%0d expected 0", bus.state_out);
    end
    checks++;
    if ({bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: A/B/Y/start/busy/err=%b expected 000000",
               {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.error});
    end
    checks++;
    if (bus.op_sel !== 4'h0) begin
      errors++; $display("FAIL reset_op_sel: op_sel=%0h expected 0", bus.op_sel);
    end
    reset = 1'b0;
    clear_counts();
    repeat (6) step();
    checks++;
    if (bus.state_out !== 3'd0 || cnt_a !== 0) begin
      errors++; $display("FAIL reset_idle: state_out=%0d enable_A pulses=%0d expected 0/0", bus.state_out, cnt_a);
    end
  endtask

  // One full load-A / load-B / execute / show transaction from S_LOAD_A.
  // delay < 0 means the unit never answers.
  task automatic run_op(input logic [3:0] op, input int delay, input string name);
    int  cyc = 0;
    int  t_start = -1;
    int  t_done = -1;
    int  t_y = -1;
    int  n5 = 0;
    int  exp_n5;
    bit  multi, exp_y, exp_err;
    logic [3:0] exp_sel;
    multi   = MULTI_REF[op];
    exp_y   = !multi || (delay >= 0 && delay < TIMEOUT_REF);
    exp_err = multi && !exp_y;
    exp_n5  = !multi ? 0 : (exp_y ? delay + 1 : TIMEOUT_REF);

    clear_counts();
    press_btn();
    wait_state(3'd2, 40, {name, "_wait_b"});
    bus.operation = op;
    exp_q.push_back(op);
    bus.btn_execute = 1'b1;
    while (bus.state_out !== 3'd7 && cyc < 700) begin
      step();
      cyc++;
      if (cyc == HOLD) bus.btn_execute = 1'b0;
      bus.op_done = 1'b0;
      if (bus.op_start === 1'b1 && t_start < 0) begin
        t_start = cyc;
        bus.operation = 4'($urandom_range(0, 15));
      end
      if (bus.state_out === 3'd5) n5++;
      if (bus.enable_Y === 1'b1) t_y = cyc;
      if (delay >= 0 && t_start >= 0 && cyc == t_start + delay) begin
        bus.op_done = 1'b1;
        t_done = cyc;
      end
    end
    bus.btn_execute = 1'b0;
    bus.op_done = 1'b0;

    checks++;
    if (bus.state_out !== 3'd7) begin
      errors++; $display("FAIL %s_show: state_out=%0d expected 7", name, bus.state_out);
    end
    checks++;
    if (cnt_a !== 1 || cnt_b !== 1) begin
      errors++; $display("FAIL %s_ab_pulses: A=%0d B=%0d expected 1/1", name, cnt_a, cnt_b);
    end
    checks++;
    if (cnt_start !== int'(multi)) begin
      errors++; $display("FAIL %s_op_start: pulses=%0d expected %0d", name, cnt_start, multi);
    end
    checks++;
    if (cnt_y !== int'(exp_y)) begin
      errors++; $display("FAIL %s_enable_Y: pulses=%0d expected %0d", name, cnt_y, exp_y);
    end
    checks++;
    if (bus.error !== exp_err) begin
      errors++; $display("FAIL %s_error: error=%0b expected %0b", name, bus.error, exp_err);
    end
    checks++;
    if (n5 !== exp_n5) begin
      errors++; $display("FAIL %s_wait_cycles: cycles=%0d expected %0d", name, n5, exp_n5);
    end
    if (multi && exp_y) begin
      checks++;
      if (t_y !== t_done + 1) begin
        errors++; $display("FAIL %s_y_latency: enable_Y at %0d expected %0d", name, t_y, t_done + 1);
      end
    end
    bus.operation = ~op;
    repeat (2) step();
    exp_sel = exp_q.pop_front();
    checks++;
    if (bus.op_sel !== exp_sel) begin
      errors++; $display("FAIL %s_op_sel: op_sel=%0h expected %0h", name, bus.op_sel, exp_sel);
    end
    checks++;
    if (overlap !== 0 || busy_bad !== 0) begin
      errors++; $display("FAIL %s_exclusive_busy: overlap=%0d busy_bad=%0d expected 0/0", name, overlap, busy_bad);
    end
  endtask

  task automatic test_single_cycle();
    run_op(4'h1, -1, "add");
    return_to_a("add_ret");
    for (int i = 0; i < 3; i++) begin
      run_op(4'($urandom_range(0, 7)), -1, "single_rand");
      return_to_a("single_ret");
    end
  endtask

  task automatic test_multi_cycle();
    run_op(4'h9, 5, "multi9");
    return_to_a("multi9_ret");
    for (int i = 0; i < 3; i++) begin
      run_op(4'($urandom_range(8, 15)), int'($urandom_range(1, 20)), "multi_rand");
      return_to_a("multi_ret");
    end
    run_op(4'($urandom_range(8, 15)), TIMEOUT_REF - 1, "done_at_timeout");
    return_to_a("edge_ret");
  endtask

  task automatic test_timeout();
    run_op(4'h9, -1, "timeout");
    return_to_a("timeout_ret");
  endtask

  task automatic test_ignored();
    press_btn();
    wait_state(3'd2, 40, "ign_wait_b");
    clear_counts();
    bus.op_done = 1'b1;
    step();
    bus.op_done = 1'b0;
    repeat (5) step();
    checks++;
    if (bus.state_out !== 3'd2 || cnt_b !== 0 || cnt_y !== 0) begin
      errors++; $display("FAIL ign_done_in_wait_b: state=%0d B=%0d Y=%0d expected 2/0/0", bus.state_out, cnt_b, cnt_y);
    end
    bus.operation = 4'h9;
    press_btn();
    wait_state(3'd5, 60, "ign_reach_wait");
    press_btn();
    checks++;
    if (bus.state_out !== 3'd5) begin
      errors++; $display("FAIL ign_press_busy: state_out=%0d expected 5", bus.state_out);
    end
    bus.op_done = 1'b1;
    step();
    bus.op_done = 1'b0;
    wait_state(3'd7, 10, "ign_show");
    repeat (10) step();
    checks++;
    if (bus.state_out !== 3'd7 || cnt_a !== 0 || cnt_b !== 1 || cnt_y !== 1 || cnt_start !== 1) begin
      errors++;
      $display("FAIL ign_totals: state=%0d A=%0d B=%0d Y=%0d start=%0d expected 7/0/1/1/1",
               bus.state_out, cnt_a, cnt_b, cnt_y, cnt_start);
    end
    return_to_a("ign_ret");
  endtask

  task automatic test_reset_mid();
    press_btn();
    wait_state(3'd2, 40, "rst_wait_b");
    bus.operation = 4'h9;
    press_btn();
    wait_state(3'd5, 60, "rst_reach_wait");
    bus.btn_execute = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if (bus.state_out !== 3'd0) begin
      errors++; $display("FAIL rst_mid_state: state_out=%0d expected 0", bus.state_out);
    end
    checks++;
    if ({bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.error} !== 6'b0 ||
        bus.op_sel !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: A/B/Y/start/busy/err=%b op_sel=%0h expected 000000/0",
               {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.error}, bus.op_sel);
    end
    reset = 1'b0;
    clear_counts();
    repeat (HOLD + 8) step();
    bus.btn_execute = 1'b0;
    repeat (4) step();
    checks++;
    if (bus.state_out !== 3'd0 || cnt_a !== 0 || cnt_start !== 0) begin
      errors++;
      $display("FAIL rst_held_btn: state=%0d A=%0d start=%0d expected 0/0/0", bus.state_out, cnt_a, cnt_start);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
`ifdef BTN_DEBOUNCE_EN
    bus.btn_execute = 1'b1;
    repeat (10) step();
    bus.btn_execute = 1'b0;
    repeat (20) step();
    checks++;
    if (bus.state_out !== 3'd0 || cnt_a !== 0) begin
      errors++; $display("FAIL glitch_filtered: state=%0d A=%0d expected 0/0", bus.state_out, cnt_a);
    end
    bus.btn_execute = 1'b1;
    repeat (20) step();
    bus.btn_execute = 1'b0;
    repeat (6) step();
    checks++;
    if (bus.state_out !== 3'd2 || cnt_a !== 1 || cnt_b !== 0) begin
      errors++; $display("FAIL glitch_hold_one_press: state=%0d A=%0d B=%0d expected 2/1/0", bus.state_out, cnt_a, cnt_b);
    end
`else
    bus.operation = 4'h1;
    bus.btn_execute = 1'b1;
    step();
    bus.btn_execute = 1'b0;
    repeat (4) step();
    bus.btn_execute = 1'b1;
    step();
    bus.btn_execute = 1'b0;
    wait_state(3'd7, 40, "glitch_two_presses");
    checks++;
    if (cnt_a !== 1 || cnt_b !== 1 || cnt_y !== 1) begin
      errors++; $display("FAIL glitch_pulses: A=%0d B=%0d Y=%0d expected 1/1/1", cnt_a, cnt_b, cnt_y);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.btn_execute = 1'b0;
    bus.operation = 4'h0;
    bus.op_done = 1'b0;
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_glitch();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
